// File: rtl/csr_file_if.sv
// Pipeline-side interface of the machine-mode CSR file: read port, writeback
// commit, retire/trap/mret events, and the registered redirect back to fetch.
interface csr_file_if;
  logic [11:0] ra;
  logic [63:0] rd;
  logic        wvalid;
  logic [11:0] wa;
  logic [63:0] wd;
  logic        retire;
  logic        trap_valid;
  logic [63:0] trap_cause;
  logic [63:0] trap_pc;
  logic [63:0] trap_tval;
  logic        mret;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  mode;

  modport master (
    output ra, wvalid, wa, wd, retire, trap_valid, trap_cause, trap_pc, trap_tval, mret,
    input  rd, redirect_valid, redirect_pc, mode
  );

  modport slave (
    input  ra, wvalid, wa, wd, retire, trap_valid, trap_cause, trap_pc, trap_tval, mret,
    output rd, redirect_valid, redirect_pc, mode
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR register file: operand read for the CSR ALU, writeback commit,
// mcycle/minstret counters, trap entry and mret return with a one-cycle redirect.
module csr_file #(
  parameter logic [63:0] MTVEC_RESET = 64'h0
) (
  input logic       clk,
  input logic       reset,
  csr_file_if.slave bus
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [1:0] PRIV_M = 2'b11;

  logic        st_mie_q, st_mie_d;
  logic        st_mpie_q, st_mpie_d;
  logic [1:0]  st_mpp_q, st_mpp_d;
  logic [63:0] mie_q, mie_d;
  logic [63:0] mip_q, mip_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mtval_q, mtval_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [1:0]  mode_q, mode_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;

  logic [63:0] mstatus_val;
  logic        do_mret;
  logic        do_write;

  // Only MIE, MPIE and MPP exist; every other mstatus bit is hardwired to 0.
  assign mstatus_val = {51'b0, st_mpp_q, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};

  assign do_mret  = bus.mret & ~bus.trap_valid;
  assign do_write = bus.wvalid & ~bus.trap_valid & ~bus.mret;

  always_comb begin
    bus.rd = 64'h0;
    unique case (bus.ra)
      CSR_MSTATUS:  bus.rd = mstatus_val;
      CSR_MIE:      bus.rd = mie_q;
      CSR_MTVEC:    bus.rd = mtvec_q;
      CSR_MSCRATCH: bus.rd = mscratch_q;
      CSR_MEPC:     bus.rd = mepc_q;
      CSR_MCAUSE:   bus.rd = mcause_q;
      CSR_MTVAL:    bus.rd = mtval_q;
      CSR_MIP:      bus.rd = mip_q;
      CSR_MCYCLE:   bus.rd = mcycle_q;
      CSR_MINSTRET: bus.rd = minstret_q;
      CSR_MHARTID:  bus.rd = 64'h0;
      default:      bus.rd = 64'h0;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path can infer a latch.
    st_mie_d         = st_mie_q;
    st_mpie_d        = st_mpie_q;
    st_mpp_d         = st_mpp_q;
    mie_d            = mie_q;
    mip_d            = mip_q;
    mscratch_d       = mscratch_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mode_d           = mode_q;
    mcycle_d         = mcycle_q + 64'd1;
    minstret_d       = minstret_q + {63'b0, bus.retire};
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (bus.trap_valid) begin
      mepc_d           = bus.trap_pc & ~64'h1;
      mcause_d         = bus.trap_cause;
      mtval_d          = bus.trap_tval;
      st_mpie_d        = st_mie_q;
      st_mie_d         = 1'b0;
      st_mpp_d         = mode_q;
      mode_d           = PRIV_M;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mtvec_q & ~64'h3;
    end else if (do_mret) begin
      mode_d           = st_mpp_q;
      st_mie_d         = st_mpie_q;
      st_mpie_d        = 1'b1;
      st_mpp_d         = 2'b00;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else if (do_write) begin
      // A counter write replaces that cycle's increment outright.
      unique case (bus.wa)
        CSR_MSTATUS: begin
          st_mie_d  = bus.wd[3];
          st_mpie_d = bus.wd[7];
          st_mpp_d  = bus.wd[12:11];
        end
        CSR_MIE:      mie_d      = bus.wd;
        CSR_MTVEC:    mtvec_d    = bus.wd;
        CSR_MSCRATCH: mscratch_d = bus.wd;
        CSR_MEPC:     mepc_d     = bus.wd & ~64'h1;
        CSR_MCAUSE:   mcause_d   = bus.wd;
        CSR_MTVAL:    mtval_d    = bus.wd;
        CSR_MIP:      mip_d      = bus.wd;
        CSR_MCYCLE:   mcycle_d   = bus.wd;
        CSR_MINSTRET: minstret_d = bus.wd;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_mie_q         <= 1'b0;
      st_mpie_q        <= 1'b0;
      st_mpp_q         <= 2'b00;
      mie_q            <= 64'h0;
      mip_q            <= 64'h0;
      mscratch_q       <= 64'h0;
      mcause_q         <= 64'h0;
      mtval_q          <= 64'h0;
      mtvec_q          <= MTVEC_RESET;
      mepc_q           <= 64'h0;
      mcycle_q         <= 64'h0;
      minstret_q       <= 64'h0;
      mode_q           <= PRIV_M;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'h0;
    end else begin
      st_mie_q         <= st_mie_d;
      st_mpie_q        <= st_mpie_d;
      st_mpp_q         <= st_mpp_d;
      mie_q            <= mie_d;
      mip_q            <= mip_d;
      mscratch_q       <= mscratch_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcycle_q         <= mcycle_d;
      minstret_q       <= minstret_d;
      mode_q           <= mode_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.mode           = mode_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected reads and redirects,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_csr_file;

  logic clk;
  logic reset;
  csr_file_if bus();

  csr_file #(.MTVEC_RESET(64'h8000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int { SEL_RD, SEL_MODE, SEL_RV } sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [63:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] redir_q[$];
  logic        sample_req;
  int          tests;
  int          fails;

  always @(negedge clk) begin
    chk_t        c;
    logic [63:0] act;
    logic [63:0] e;
    if (sample_req) begin
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.sel)
          SEL_RD:   act = bus.rd;
          SEL_MODE: act = {62'b0, bus.mode};
          default:  act = {63'b0, bus.redirect_valid};
        endcase
        tests++;
        if (act !== c.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
    if (bus.redirect_valid === 1'b1) begin
      tests++;
      if (redir_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_redirect: got pc %h expected no pulse", bus.redirect_pc);
      end else begin
        e = redir_q.pop_front();
        if (bus.redirect_pc !== e) begin
          fails++;
          $display("FAIL redirect_pc: got %h expected %h", bus.redirect_pc, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.wvalid     = 1'b0;
    bus.retire     = 1'b0;
    bus.trap_valid = 1'b0;
    bus.mret       = 1'b0;
  endtask

  task automatic push_rd(input logic [11:0] addr, input logic [63:0] exp, input string name);
    chk_t c;
    bus.ra = addr;
    c.name = name; c.sel = SEL_RD; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_mode(input logic [1:0] exp, input string name);
    chk_t c;
    c.name = name; c.sel = SEL_MODE; c.exp = {62'b0, exp};
    chk_q.push_back(c);
  endtask

  task automatic push_rv(input logic exp, input string name);
    chk_t c;
    c.name = name; c.sel = SEL_RV; c.exp = {63'b0, exp};
    chk_q.push_back(c);
  endtask

  task automatic sample();
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [63:0] data);
    bus.wvalid = 1'b1;
    bus.wa     = addr;
    bus.wd     = data;
    step();
  endtask

  task automatic set_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval);
    bus.trap_valid = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0; fails = 0; sample_req = 1'b0;
    reset = 1'b1;
    bus.ra = 12'h0; bus.wvalid = 1'b0; bus.wa = 12'h0; bus.wd = 64'h0;
    bus.retire = 1'b0; bus.trap_valid = 1'b0; bus.trap_cause = 64'h0;
    bus.trap_pc = 64'h0; bus.trap_tval = 64'h0; bus.mret = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values and free-running mcycle
    push_rd(12'h305, 64'h8000_0000, "mtvec_reset");
    push_mode(2'd3, "mode_reset");
    push_rv(1'b0, "redirect_valid_reset");
    sample();
    repeat (4) step();
    push_rd(12'hB00, 64'd5, "mcycle_after_5");
    sample();

    // Masked and ignored writes
    wr(12'h300, '1);
    push_rd(12'h300, 64'h1888, "mstatus_mask");
    sample();
    wr(12'h341, 64'h1003);
    push_rd(12'h341, 64'h1002, "mepc_bit0");
    sample();
    wr(12'h123, 64'd5);
    push_rd(12'h123, 64'h0, "unmapped");
    sample();
    wr(12'hF14, 64'h77);
    push_rd(12'hF14, 64'h0, "mhartid");
    sample();

    // Trap entry with MIE=1, mtvec low bits ignored
    wr(12'h305, 64'h1001);
    set_trap(64'd2, 64'h2000, 64'hdead);
    redir_q.push_back(64'h1000);
    step();
    push_rd(12'h341, 64'h2000, "trap_mepc");
    push_rv(1'b1, "trap_redirect_valid");
    push_mode(2'd3, "trap_mode");
    sample();
    push_rd(12'h342, 64'd2, "trap_mcause");
    push_rv(1'b0, "redirect_one_cycle");
    sample();
    push_rd(12'h343, 64'hdead, "trap_mtval");
    sample();
    push_rd(12'h300, 64'h1880, "trap_mstatus");
    sample();

    // mret to U-mode
    wr(12'h300, 64'h80);
    wr(12'h341, 64'h3000);
    bus.mret = 1'b1;
    redir_q.push_back(64'h3000);
    step();
    push_rd(12'h300, 64'h88, "mret_mstatus");
    push_mode(2'd0, "mret_mode");
    sample();

    // Trap beats mret and write in the same cycle
    set_trap(64'd8, 64'h4001, 64'h55);
    bus.mret = 1'b1;
    bus.wvalid = 1'b1; bus.wa = 12'h340; bus.wd = 64'd7;
    redir_q.push_back(64'h1000);
    step();
    push_rd(12'h340, 64'h0, "prio_mscratch");
    push_mode(2'd3, "prio_mode");
    sample();
    push_rd(12'h341, 64'h4000, "prio_mepc");
    sample();
    push_rd(12'h300, 64'h80, "prio_mstatus");
    sample();

    // Back-to-back trap then mret: mret uses the freshly written mepc
    set_trap(64'd1, 64'h5000, 64'h0);
    redir_q.push_back(64'h1000);
    step();
    bus.mret = 1'b1;
    bus.wvalid = 1'b1; bus.wa = 12'h340; bus.wd = 64'd9;
    redir_q.push_back(64'h5000);
    step();
    push_rd(12'h300, 64'h80, "b2b_mstatus");
    push_mode(2'd3, "b2b_mode");
    sample();
    push_rd(12'h340, 64'h0, "mret_drops_write");
    sample();

    // Counter write beats increment; retire counting; mcycle wrap
    bus.retire = 1'b1;
    wr(12'hB02, 64'd100);
    push_rd(12'hB02, 64'd100, "minstret_write");
    sample();
    bus.retire = 1'b1;
    step();
    push_rd(12'hB02, 64'd101, "minstret_retire");
    sample();
    wr(12'hB00, '1);
    push_rd(12'hB00, '1, "mcycle_max");
    sample();
    push_rd(12'hB00, 64'h0, "mcycle_wrap");
    sample();

    // Reset asserted during a trap cycle discards the trap
    set_trap(64'd3, 64'h6000, 64'h1);
    #2 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    push_rd(12'h341, 64'h0, "rst_trap_mepc");
    push_mode(2'd3, "rst_trap_mode");
    push_rv(1'b0, "rst_trap_no_redirect");
    sample();
    push_rd(12'h305, 64'h8000_0000, "rst_mtvec");
    sample();

    repeat (3) step();
    tests++;
    if (redir_q.size() != 0) begin
      fails++;
      $display("FAIL missing_redirects: got %0d outstanding expected 0", redir_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file that sits directly downstream of the execute-stage CSR ALU. It supplies the CSR read operand to the CSR ALU and commits the ALU's result when the instruction reaches writeback. It also owns the free-running `mcycle`/`minstret` counters, trap entry, and `mret` return, and issues a registered one-cycle pipeline redirect for both.

## Interface
Parameters:
- `MTVEC_RESET`, default `64'h0`: reset value of `mtvec`.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `ra`, input, 12: CSR read address.
- `rd`, output, 64: CSR read data; combinational from `ra`.
- `wvalid`, input, 1: commit a CSR write this cycle.
- `wa`, input, 12: CSR write address.
- `wd`, input, 64: write data, taken from the CSR ALU result.
- `retire`, input, 1: one instruction retires this cycle.
- `trap_valid`, input, 1: take a trap this cycle.
- `trap_cause`, input, 64: value loaded into `mcause`.
- `trap_pc`, input, 64: faulting PC, loaded into `mepc`.
- `trap_tval`, input, 64: value loaded into `mtval`.
- `mret`, input, 1: execute `mret` this cycle.
- `redirect_valid`, output, 1: one-cycle pulse requesting a PC redirect.
- `redirect_pc`, output, 64: redirect target.
- `mode`, output, 2: current privilege level; 3 = M, 0 = U.

## Operation
Implemented CSRs and their behaviour:
- `mstatus` (0x300): only MIE[3], MPIE[7] and MPP[12:11] are stored. All other bits read 0 and ignore writes.
- `mie` (0x304), `mip` (0x344), `mscratch` (0x340), `mcause` (0x342), `mtval` (0x343): full 64-bit read/write.
- `mtvec` (0x305): full 64-bit read/write.
- `mepc` (0x341): bit 0 is forced to 0 on any write.
- `mcycle` (0xB00): increments by 1 every cycle.
- `minstret` (0xB02): increments by 1 on each cycle with `retire`=1.
- `mhartid` (0xF14): reads 0; writes ignored.
- Any other address: reads 0; writes ignored.

Priority when events coincide: `trap_valid` > `mret` > `wvalid`.
- Any lower-priority event in the same cycle is dropped entirely.
- Counter auto-increments still happen in that cycle.

Trap entry (`trap_valid`=1):
- `mepc` ← `trap_pc` with bit 0 cleared.
- `mcause` ← `trap_cause`; `mtval` ← `trap_tval`.
- MPIE ← MIE; MIE ← 0; MPP ← `mode`; `mode` ← 3.
- `redirect_pc` ← {`mtvec`[63:2], 2'b00}. Direct mode only; `mtvec`[1:0] is ignored for the redirect.

`mret` (`mret`=1 and no trap):
- `mode` ← MPP; MIE ← MPIE; MPIE ← 1; MPP ← 0.
- `redirect_pc` ← `mepc`.

Counters:
- A `wvalid` write to `mcycle` or `minstret` wins over that counter's increment in the same cycle: the written value is stored, with no +1.
- Both counters wrap from 2^64−1 to 0.

`rd` always reflects the registered state. A write becomes visible on `rd` in the cycle after its commit edge; there is no internal forwarding.

## Timing
- Reset values: all CSRs 0 except `mtvec` = `MTVEC_RESET`; `mode` = 3; `redirect_valid` = 0; `redirect_pc` = 0.
- Reset acts immediately, without waiting for a clock edge.
- Reset asserted in the same cycle as a trap, `mret` or write discards that event: no redirect pulse follows, and state holds reset values.
- Write, trap and `mret` latency: state updates at the edge ending the request cycle.
- `redirect_valid` is high for exactly the one cycle after a trap or `mret` cycle.
- `redirect_pc` is registered; it holds its value while `redirect_valid` = 0.
- Back-to-back trap then `mret` produces two consecutive `redirect_valid` pulses. The `mret` target uses the `mepc` just written by the trap.
- `mcycle` read at cycle N after reset deassertion returns N. The first edge after deassertion yields 1.

## Test plan
- **Reset and counting:** with `MTVEC_RESET`=`64'h8000_0000`, read 0x305 → `64'h8000_0000`; read 0xB00 five cycles after reset release → 5; `mode`=3; `redirect_valid`=0.
- **Masked writes:** write 0x300 = all-ones, then read 0x300 → `64'h1888`. Write 0x341 = `64'h1003`, then read → `64'h1002`. Write 0x123 = 5, then read 0x123 → 0.
- **Trap entry:** with MIE=1 and `mtvec`=`64'h1001`, pulse `trap_valid` (cause 2, pc `64'h2000`, tval `64'hdead`). Next cycle: `redirect_valid`=1, `redirect_pc`=`64'h1000`; `mepc`=`64'h2000`, `mcause`=2, `mtval`=`64'hdead`, `mstatus`=`64'h1880`.
- **`mret` return:** preset MPP=0, MPIE=1, `mepc`=`64'h3000`, then pulse `mret`. Next cycle: `redirect_pc`=`64'h3000`, `mode`=0, `mstatus`=`64'h88`.
- **Same-cycle priority:** `trap_valid`+`mret`+`wvalid`(0x340, 7) together → trap taken, `mscratch` unchanged. `wvalid`(0xB02, 100) together with `retire` → `minstret`=100.
- **Reset mid-trap:** assert `reset` asynchronously in the `trap_valid` cycle → no `redirect_valid` pulse; `mepc`=0 and `mode`=3 after release.
